hyperspace_pad_bridge: RTL and testbench

- Chip-side endpoint of the HyperSpace pad streaming interface; the counterpart to the off-chip stream source and sink.
- Inbound: samples the 8-bit pad stream (valid/last/ready) and buffers it into a core-facing valid/ready stream.
- Outbound: takes the core's 16-bit result stream and drives it onto the pads with valid/last, honouring pad out_ready.
- Sits in the user project between the mprj_io pads and the HyperSpace core.

---
 rtl/hyperspace_pad_bridge_if.sv | 19 +
 rtl/hyperspace_pad_bridge.sv | 93 +++++++++
 tb/tb_hyperspace_pad_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hyperspace_pad_bridge_if.sv
// hyperspace_pad_bridge_if: core-facing streams; inbound core_in_* (8-bit) and outbound core_out_* (16-bit), master=core, slave=bridge
interface hyperspace_pad_bridge_if;
  logic        core_in_valid;
  logic [7:0]  core_in_data;
  logic        core_in_last;
  logic        core_in_ready;
  logic        core_out_valid;
  logic [15:0] core_out_data;
  logic        core_out_last;
  logic        core_out_ready;
  modport master (
    input  core_in_valid, core_in_data, core_in_last, core_out_ready,
    output core_in_ready, core_out_valid, core_out_data, core_out_last
  );
  modport slave (
    output core_in_valid, core_in_data, core_in_last, core_out_ready,
    input  core_in_ready, core_out_valid, core_out_data, core_out_last
  );
endinterface

// File: rtl/hyperspace_pad_bridge.sv
// hyperspace_pad_bridge: pad<->core stream bridge; ports clock/resetb, enable, io_in/io_out/io_oeb pads, bus core streams, in_overflow, in/out beat counters
module hyperspace_pad_bridge #(
  parameter int IN_DEPTH = 8,
  parameter int IN_SLACK = 4,
  parameter int CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 enable,
  input  logic [37:0]          io_in,
  output logic [37:0]          io_out,
  output logic [37:0]          io_oeb,
  hyperspace_pad_bridge_if.slave bus,
  output logic                 in_overflow,
  output logic [CNT_W-1:0]     in_beat_cnt,
  output logic [CNT_W-1:0]     out_beat_cnt
);
  localparam int AW = $clog2(IN_DEPTH);
  logic             r_in_valid, r_in_last, r_in_ready, r_ovf, r_out_ready;
  logic [7:0]       r_in_data;
  logic [8:0]       r_mem [IN_DEPTH];
  logic [AW:0]      r_wp, r_rp;
  logic [CNT_W-1:0] r_in_cnt, r_out_cnt;
  logic [15:0]      r_ob_data [2];
  logic [1:0]       r_ob_last, r_ob_cnt;
  logic [AW:0]      w_occ, w_occ_nxt;
  logic [1:0]       w_ob_cnt_nxt;
  logic [7:0]       w_rev;
  logic             w_pop, w_full, w_push, w_drop;
  logic             w_ob_push, w_ob_pop, w_ob_wi, w_out_valid;
  logic             w_unused;
  always_comb begin
    w_occ        = r_wp - r_rp;
    w_pop        = (w_occ != '0) && bus.core_in_ready;
    w_full       = w_occ == (AW+1)'(IN_DEPTH);
    w_push       = r_in_valid && (!w_full || w_pop);
    w_drop       = r_in_valid && w_full && !w_pop;
    w_occ_nxt    = w_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_out_valid  = (r_ob_cnt != 2'd0) && enable;
    w_ob_pop     = w_out_valid && io_in[18];
    w_ob_push    = bus.core_out_valid && r_out_ready;
    w_ob_cnt_nxt = r_ob_cnt + 2'(w_ob_push) - 2'(w_ob_pop);
    w_ob_wi      = (r_ob_cnt == 2'd2) || ((r_ob_cnt == 2'd1) && !w_ob_pop);
  end
  assign w_rev = {<<{io_in[37:30]}};
  assign w_unused = &{1'b0, io_in[27:19], io_in[17:0]};
  assign bus.core_in_valid = w_occ != '0;
  assign {bus.core_in_last, bus.core_in_data} = r_mem[r_rp[AW-1:0]];
  assign bus.core_out_ready = r_out_ready;
  assign io_out = {10'd0, r_in_ready, 9'd0, w_out_valid, r_ob_last[0], r_ob_data[0]};
  assign io_oeb = 38'h3F_F7FC_0000;
  assign in_overflow = r_ovf;
  assign in_beat_cnt = r_in_cnt;
  assign out_beat_cnt = r_out_cnt;
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_in_valid  <= 1'b0;
      r_in_last   <= 1'b0;
      r_in_data   <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_in_ready  <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_ob_cnt    <= '0;
      r_out_ready <= 1'b0;
      r_ob_data   <= '{default: '0};
      r_ob_last   <= '0;
    end else begin
      r_in_valid  <= io_in[28];
      r_in_last   <= io_in[29];
      r_in_data   <= w_rev;
      r_wp        <= r_wp + (AW+1)'(w_push);
      r_rp        <= r_rp + (AW+1)'(w_pop);
      r_ovf       <= r_ovf || w_drop;
      r_in_cnt    <= r_in_cnt + CNT_W'(w_push);
      r_in_ready  <= enable && (w_occ_nxt <= (AW+1)'(IN_DEPTH - IN_SLACK));
      r_ob_cnt    <= w_ob_cnt_nxt;
      r_out_ready <= enable && (w_ob_cnt_nxt <= 2'd1);
      r_out_cnt   <= r_out_cnt + CNT_W'(w_ob_pop);
      if (w_ob_pop) begin
        r_ob_data[0] <= r_ob_data[1];
        r_ob_last[0] <= r_ob_last[1];
      end
      if (w_ob_push) begin
        r_ob_data[w_ob_wi] <= bus.core_out_data;
        r_ob_last[w_ob_wi] <= bus.core_out_last;
      end
    end
  end
  always_ff @(posedge clock) if (w_push) r_mem[r_wp[AW-1:0]] <= {r_in_last, r_in_data};
endmodule

// File: tb/tb_hyperspace_pad_bridge.sv
// tb_hyperspace_pad_bridge: randomized bench with queue-based reference model for hyperspace_pad_bridge
module tb_hyperspace_pad_bridge;
  localparam int IN_DEPTH = 8;
  localparam int IN_SLACK = 4;
  logic        clock = 1'b0;
  logic        resetb, enable;
  logic [37:0] io_in, io_out, io_oeb;
  logic        in_overflow;
  logic [15:0] in_beat_cnt, out_beat_cnt;
  int n_run = 0, n_fail = 0;
  int tx, rx, widx, ridx;
  logic acc, po;
  logic [7:0] s_bytes [2048];
  logic [8:0]  m_in_q [$];
  logic [16:0] m_ob_q [$];
  logic m_fv = 0, m_fl = 0, m_ovf = 0, m_irdy = 0, m_ordy = 0;
  logic [7:0]  m_fd = 0;
  logic [15:0] m_icnt = 0, m_ocnt = 0;
  hyperspace_pad_bridge_if bus();
  hyperspace_pad_bridge #(.IN_DEPTH(IN_DEPTH), .IN_SLACK(IN_SLACK), .CNT_W(16)) dut (
    .clock(clock), .resetb(resetb), .enable(enable), .io_in(io_in), .io_out(io_out),
    .io_oeb(io_oeb), .bus(bus), .in_overflow(in_overflow), .in_beat_cnt(in_beat_cnt),
    .out_beat_cnt(out_beat_cnt)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    logic ipop, ifull, opop;
    if (!resetb) begin
      m_in_q.delete(); m_ob_q.delete();
      m_ovf = 0; m_irdy = 0; m_ordy = 0; m_icnt = 0; m_ocnt = 0;
      m_fv = 0; m_fl = 0; m_fd = 0;
    end else begin
      ipop  = m_in_q.size() != 0 && bus.core_in_ready;
      ifull = m_in_q.size() == IN_DEPTH;
      if (ipop) m_in_q.delete(0);
      if (m_fv && (!ifull || ipop)) begin
        m_in_q.push_back({m_fl, m_fd});
        m_icnt++;
      end else if (m_fv) m_ovf = 1;
      m_irdy = enable && m_in_q.size() <= IN_DEPTH - IN_SLACK;
      opop = m_ob_q.size() != 0 && enable && io_in[18];
      if (opop) begin
        m_ob_q.delete(0);
        m_ocnt++;
      end
      if (bus.core_out_valid && m_ordy) m_ob_q.push_back({bus.core_out_last, bus.core_out_data});
      m_ordy = enable && m_ob_q.size() <= 1;
      m_fv = io_in[28];
      m_fl = io_in[29];
      for (int i = 0; i < 8; i++) m_fd[i] = io_in[37-i];
    end
  endtask
  task automatic check_all();
    check("oeb", io_oeb, 38'h3FF7FC0000);
    check("undriven", io_out & 38'h3FF7FC0000, 0);
    check("in_rdy", io_out[27], m_irdy);
    check("in_vld", bus.core_in_valid, m_in_q.size() != 0);
    if (m_in_q.size() != 0) check("in_beat", {bus.core_in_last, bus.core_in_data}, m_in_q[0]);
    check("ovf", in_overflow, m_ovf);
    check("in_cnt", in_beat_cnt, m_icnt);
    check("out_vld", io_out[17], m_ob_q.size() != 0 && enable);
    if (m_ob_q.size() != 0) check("out_beat", io_out[16:0], m_ob_q[0]);
    check("out_rdy", bus.core_out_ready, m_ordy);
    check("out_cnt", out_beat_cnt, m_ocnt);
  endtask
  task automatic tick();
    @(negedge clock);
    model_step();
    check_all();
  endtask
  task automatic pad(input logic v, input logic l, input logic [7:0] d, input logic ordy);
    io_in = 38'({$urandom, $urandom});
    io_in[28] = v;
    io_in[29] = l;
    io_in[18] = ordy;
    for (int i = 0; i < 8; i++) io_in[37-i] = d[i];
  endtask
  task automatic do_reset();
    resetb = 0;
    bus.core_out_valid = 1'($urandom);
    bus.core_in_ready = 1'($urandom);
    io_in = 38'({$urandom, $urandom});
    repeat (2) tick();
    check("rst_io", io_out, 0);
    check("rst_ivld", bus.core_in_valid, 0);
    check("rst_ordy0", bus.core_out_ready, 0);
    check("rst_icnt", in_beat_cnt, 0);
    check("rst_ocnt", out_beat_cnt, 0);
    check("rst_ovf", in_overflow, 0);
    resetb = 1;
    bus.core_out_valid = 0;
    bus.core_in_ready = 0;
    pad(0, 0, 0, 0);
  endtask
  initial begin
    resetb = 0;
    enable = 1;
    bus.core_in_ready = 0;
    bus.core_out_valid = 0;
    bus.core_out_data = 0;
    bus.core_out_last = 0;
    pad(0, 0, 0, 0);
    do_reset();
    tick();
    check("rst_ordy1", bus.core_out_ready, 1);
    do_reset();
    io_in = '0;
    io_in[37:30] = 8'b00000001;
    io_in[29:28] = 2'b11;
    tick();
    check("p_early", bus.core_in_valid, 0);
    pad(0, 0, 0, 0);
    tick();
    check("p_vld", bus.core_in_valid, 1);
    check("p_data", bus.core_in_data, 8'h80);
    check("p_last", bus.core_in_last, 1);
    bus.core_in_ready = 1;
    tick();
    bus.core_in_ready = 0;
    do_reset();
    foreach (s_bytes[i]) s_bytes[i] = 8'($urandom);
    tx = 0;
    rx = 0;
    for (int c = 0; c < 20000 && rx < 2048; c++) begin
      tick();
      bus.core_in_ready = $urandom_range(3) != 0;
      if (bus.core_in_valid && bus.core_in_ready) begin
        check("s_beat", {bus.core_in_last, bus.core_in_data}, {rx == 2047, s_bytes[rx]});
        rx++;
      end
      if (io_out[27] && tx < 2048 && $urandom_range(7) != 0) begin
        pad(1, tx == 2047, s_bytes[tx], 0);
        tx++;
      end else pad(0, 0, 0, 0);
    end
    check("s_rx", rx, 2048);
    check("s_cnt", in_beat_cnt, 2048);
    check("s_ovf", in_overflow, 0);
    do_reset();
    tx = 0;
    repeat (20) begin
      tick();
      if (io_out[27]) begin
        pad(1, 0, tx[7:0], 0);
        tx++;
      end else pad(0, 0, 0, 0);
    end
    check("h_cnt", in_beat_cnt, tx);
    check("h_max", tx <= IN_DEPTH, 1);
    check("h_ovf", in_overflow, 0);
    do_reset();
    repeat (12) begin
      pad(1, 0, 8'($urandom), 0);
      tick();
    end
    pad(0, 0, 0, 0);
    repeat (3) tick();
    check("f_cnt", in_beat_cnt, 8);
    check("f_ovf", in_overflow, 1);
    check("f_rdy", io_out[27], 0);
    bus.core_in_ready = 1;
    repeat (10) tick();
    check("f_empty", bus.core_in_valid, 0);
    do_reset();
    widx = 0;
    ridx = 0;
    acc = 0;
    po = 0;
    for (int c = 0; c < 20000 && ridx < 1536; c++) begin
      tick();
      if (acc) widx++;
      bus.core_out_valid = widx < 1536 && $urandom_range(3) != 0;
      bus.core_out_data = 16'(widx);
      bus.core_out_last = widx == 1535;
      acc = bus.core_out_valid && bus.core_out_ready;
      po = ~po;
      pad(0, 0, 0, po);
      if (io_out[17] && po) begin
        check("o_word", io_out[16:0], {ridx == 1535, 16'(ridx)});
        ridx++;
      end
    end
    check("o_rx", ridx, 1536);
    bus.core_out_valid = 0;
    repeat (3) begin
      pad(0, 0, 0, 1);
      tick();
      check("o_nodup", io_out[17], 0);
    end
    check("o_cnt", out_beat_cnt, 1536);
    do_reset();
    bus.core_out_valid = 1;
    bus.core_out_data = 16'h1234;
    bus.core_out_last = 0;
    repeat (4) tick();
    check("r_full", io_out[17], 1);
    resetb = 0;
    tick();
    check("r_ovld", io_out[17], 0);
    check("r_ocnt", out_beat_cnt, 0);
    check("r_ordy", bus.core_out_ready, 0);
    resetb = 1;
    bus.core_out_valid = 0;
    pad(0, 0, 0, 1);
    tick();
    check("r_idle", io_out[17], 0);
    check("r_ordy1", bus.core_out_ready, 1);
    bus.core_out_valid = 1;
    bus.core_out_data = 16'hABCD;
    bus.core_out_last = 1;
    tick();
    bus.core_out_valid = 0;
    check("r_lat", io_out[17:0], {2'b11, 16'hABCD});
    tick();
    check("r_cnt1", out_beat_cnt, 1);
    do_reset();
    repeat (800) begin
      tick();
      resetb = $urandom_range(49) != 0;
      enable = $urandom_range(7) != 0;
      bus.core_in_ready = 1'($urandom);
      bus.core_out_valid = 1'($urandom);
      bus.core_out_data = 16'($urandom);
      bus.core_out_last = 1'($urandom);
      pad(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
